mux_arb_rr: RTL and testbench
=============================

Name: mux_arb_rr

Overview:
- N-channel valid/ready arbitrating multiplexer: successor to the one-hot mux.
- Selection is generated internally (round-robin or fixed priority), not supplied by the caller.
- Supports locked multi-beat transfers and has a registered output stage.
- Sits in front of shared MMU resources (ATC lookup port, table-walk bus) where CPU, table walker and debug requesters contend.

Parameters:
- WIDTH, 32: payload bits per channel.
- N, 4: number of input channels, 1..16.
- RR, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.
- LOCK_EN, 1: 1 = grant held until in_last accepted; 0 = in_last ignored for arbitration, every beat re-arbitrates.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  N  per-channel request valid.
- in_ready  out  N  per-channel accept; at most one bit high.
- in_data  in  N*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
- in_last  in  N  final beat of a locked sequence.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accept.
- out_data  out  WIDTH  registered payload.
- out_last  out  1  registered in_last of the winning beat.
- out_grant  out  N  one-hot source of the current output beat.
- out_idx  out  IW  binary source index; IW = max(1, clog2(N)).

Behaviour:
- Reset (async assert, sync deassert by the integrator): out_valid=0, out_data=0, out_last=0, out_grant=0, out_idx=0, priority pointer=0, lock=0.
- in_ready is 0 while rst_n is low.
- load = ~out_valid | out_ready. One beat is accepted per cycle at most, so throughput is 1 beat/clk.
- Latency is 1 clk from acceptance to out_valid.
- grant: combinational one-hot over in_valid.
  - RR=1: first valid index at or after ptr, searching cyclically.
  - RR=0: lowest valid index.
- in_ready = grant & {N{load}}. Acceptance on channel i = in_valid[i] & in_ready[i].
- On acceptance: out_data <= in_data[i], out_last <= in_last[i], out_grant <= grant, out_idx <= i, out_valid <= 1.
- If load=1 and no channel is valid: out_valid <= 0. out_data, out_grant and out_idx hold their values, which are don't-care.
- out_valid=1 & out_ready=0: the output register is frozen and every in_ready is 0. Inputs must hold valid/data (AXI-style: no retraction once valid).
- Pointer update (RR=1): on an accepted beat that ends arbitration, ptr <= (i+1) mod N. A beat ends arbitration when LOCK_EN=0, or when in_last=1.
- Pointer with RR=0: ptr stays unused at 0.
- Lock (LOCK_EN=1):
  - An accepted beat with in_last=0 sets lock=1 and lock_idx=i.
  - While locked, grant is forced to lock_idx whether or not that channel is valid; other channels see in_ready=0.
  - An accepted beat with in_last=1 on lock_idx clears lock.
- Simultaneous final beat and new request in the same cycle: the next winner is computed from the updated ptr/lock in the following cycle. No zero-cycle handover.
- Wrap-around: with ptr=N-1, the search order is N-1, 0, 1, ... .
- N=1: the block degenerates to a registered pass-through with IW=1; out_idx is always 0.
- Reset mid-operation: a held output beat and any lock are discarded. Upstream must re-present the beat.

Decomposition:
- Package mmu_util_pkg:
  - function clog2_min1 (computes IW).
  - localparam for the maximum N (16).
  - typedef of the grant vector for the default N.
- Sub-module rr_grant: combinational.
  - Inputs: req[N], ptr[IW], rr_en, force_en, force_idx.
  - Output: one-hot gnt[N].
  - Implemented by the double-width masked priority encoder.
- The top level holds the output register, ptr, lock and handshake logic.

Test Plan:
- N=4, RR=1, LOCK_EN=0, all in_valid=1, data=i*0x11111111, out_ready=1 → out_idx sequence 0,1,2,3,0; out_data 0x00000000, 0x11111111, ..., one beat per clk after a 1-clk latency.
- RR=0, in_valid=4'b1010 held → only ch1 accepted every cycle; ch3 in_ready stays 0 (starvation by design).
- Backpressure: out_ready=0 for 3 clks with out_valid=1 → out_data stable and in_ready=0 throughout. When out_ready returns to 1 the next beat loads in the same cycle, with no bubble.
- Lock, LOCK_EN=1: ch2 sends 3 beats with last=0,0,1 while ch0 is valid; ch2 drops valid for 2 clks mid-sequence → ch0 is never granted until ch2's last beat. The next grant is ch3 if valid, else ch0 (ptr=3).
- Wrap: ptr=3, in_valid=4'b0101 → ch0 is granted; then ptr=1 → ch2 is granted.
- Async reset asserted mid-lock with out_valid=1 → out_valid=0 and in_ready=0 immediately. After release: lock=0, ptr=0, and with all channels valid the first grant is ch0.

Source files
------------

// File: rtl/mmu_util_pkg.sv
// Shared helpers for the MMU requester-side arbitration blocks.
//   clog2_min1 : index width for an N-entry vector, never less than 1 bit.
//   MaxN       : largest channel count the arbiter is meant to be built with.
//   grant_t    : one-hot grant vector for the default channel count.
package mmu_util_pkg;

   localparam int unsigned MaxN = 16;
   localparam int unsigned DefN = 4;

   typedef logic [DefN-1:0] grant_t;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_arb_rr_if.sv
// Handshake bundle of the arbitrating multiplexer.
//   in_valid/in_ready/in_data/in_last : N upstream valid/ready channels.
//   out_valid/out_ready/out_data/out_last : registered downstream channel.
//   out_grant/out_idx : one-hot and binary source of the current output beat.
// Modports: master = the side that feeds inputs and consumes the output,
//           slave  = the arbiter itself.
interface mux_arb_rr_if
   import mmu_util_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned N     = 4
);
   localparam int unsigned IW = clog2_min1(N);

   logic [N-1:0]       in_valid;
   logic [N-1:0]       in_ready;
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0]       in_last;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_last;
   logic [N-1:0]       out_grant;
   logic [IW-1:0]      out_idx;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_grant, out_idx
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_grant, out_idx
   );

endinterface

// File: rtl/rr_grant.sv
// Combinational one-hot grant generator.
//   req       : per-channel request.
//   ptr       : round-robin start index (ignored when rr_en=0).
//   rr_en     : 1 = cyclic search from ptr, 0 = lowest index wins.
//   force_en  : override the search and grant force_idx unconditionally.
//   force_idx : channel granted while force_en=1.
//   gnt       : one-hot grant, all zero when nothing is requested.
module rr_grant
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          rr_en,
   input  logic          force_en,
   input  logic [IW-1:0] force_idx,
   output logic [N-1:0]  gnt
);

   logic [N-1:0]   mask;
   logic [2*N-1:0] dbl;
   logic [2*N-1:0] g2;
   logic           found;

   always_comb begin
      mask  = '0;
      g2    = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         mask[i] = !rr_en || (i >= int'(ptr));
      end
      // Lower copy holds only requests at/after ptr, upper copy holds all of
      // them, so the first set bit is the cyclic winner.
      dbl = {req, req & mask};
      for (int k = 0; k < 2 * N; k++) begin
         if (dbl[k] && !found) begin
            g2[k] = 1'b1;
            found = 1'b1;
         end
      end
      gnt = g2[N-1:0] | g2[2*N-1:N];
      if (force_en) begin
         gnt = '0;
         for (int i = 0; i < N; i++) begin
            if (int'(force_idx) == i) gnt[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel valid/ready arbitrating multiplexer with a registered output.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset.
//   bus        : slave side of mux_arb_rr_if (N inputs, one registered output,
//                plus one-hot/binary source of the output beat).
// Parameters: WIDTH payload bits, N channels (1..16), RR round-robin vs fixed
// priority, LOCK_EN hold the grant across a multi-beat sequence until in_last.
module mux_arb_rr
   import mmu_util_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned N       = 4,
   parameter int unsigned RR      = 1,
   parameter int unsigned LOCK_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   mux_arb_rr_if.slave bus
);

   localparam int unsigned IW = clog2_min1(N);

   logic             load;
   logic             accept;
   logic             ends_arb;
   logic [N-1:0]     gnt;
   logic [IW-1:0]    sel_idx;
   logic [WIDTH-1:0] sel_data;
   logic             sel_last;
   logic [IW-1:0]    ptr_d;

   logic [IW-1:0]    ptr_q;
   logic             lock_q;
   logic [IW-1:0]    lock_idx_q;
   logic             out_valid_q;
   logic [WIDTH-1:0] out_data_q;
   logic             out_last_q;
   logic [N-1:0]     out_grant_q;
   logic [IW-1:0]    out_idx_q;

   rr_grant #(
      .N  (N),
      .IW (IW)
   ) u_grant (
      .req       (bus.in_valid),
      .ptr       (ptr_q),
      .rr_en     (RR != 0),
      .force_en  (lock_q),
      .force_idx (lock_idx_q),
      .gnt       (gnt)
   );

   assign load = ~out_valid_q | bus.out_ready;
   // rst_n gating keeps every in_ready low for the whole reset window.
   assign bus.in_ready = gnt & {N{load & rst_n}};
   assign accept       = |(bus.in_valid & bus.in_ready);

   always_comb begin
      sel_idx  = '0;
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (gnt[i]) begin
            sel_idx  = IW'(i);
            sel_data = bus.in_data[i*WIDTH +: WIDTH];
            sel_last = bus.in_last[i];
         end
      end
   end

   assign ends_arb = (LOCK_EN == 0) || sel_last;
   assign ptr_d    = (sel_idx == IW'(N - 1)) ? '0 : sel_idx + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         lock_q      <= 1'b0;
         lock_idx_q  <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_grant_q <= '0;
         out_idx_q   <= '0;
      end else begin
         if (load) begin
            out_valid_q <= accept;
            if (accept) begin
               out_data_q  <= sel_data;
               out_last_q  <= sel_last;
               out_grant_q <= gnt;
               out_idx_q   <= sel_idx;
            end
         end
         if (accept && (RR != 0) && ends_arb) ptr_q <= ptr_d;
         // While locked only lock_idx can be accepted, so a last beat here
         // always belongs to the locked channel.
         if (accept && (LOCK_EN != 0)) begin
            lock_q     <= ~sel_last;
            lock_idx_q <= sel_idx;
         end
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.out_grant = out_grant_q;
   assign bus.out_idx   = out_idx_q;

endmodule

// File: tb/tb_mux_arb_rr.sv
// Self-checking bench for mux_arb_rr: three instances (RR+lock, fixed
// priority, RR without lock) share one stimulus path selected by sel.
module tb_mux_arb_rr;
   import mmu_util_pkg::*;

   localparam int unsigned W  = 32;
   localparam int unsigned NC = (DefN <= MaxN) ? DefN : MaxN;
   localparam int unsigned IW = clog2_min1(NC);

   typedef struct packed {
      logic          rst;
      logic [1:0]    sel;
      logic [NC-1:0] valid;
      logic [NC-1:0] last;
      logic          ordy;
      logic [NC-1:0] exp_ready;
   } vec_t;

   typedef struct packed {
      logic [IW-1:0] idx;
      logic [W-1:0]  data;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int              sel;
   logic [NC-1:0]   drv_valid;
   logic [NC-1:0]   drv_last;
   logic [NC*W-1:0] drv_data;
   logic            drv_ordy;

   logic [NC-1:0]   obs_ready;
   logic            obs_valid;
   logic [W-1:0]    obs_data;
   logic            obs_last;
   grant_t          obs_grant;
   logic [IW-1:0]   obs_idx;

   beat_t       sb[$];
   vec_t        tbl[$];
   int unsigned cnt[NC];
   int          checks;
   int          errors;

   mux_arb_rr_if #(.WIDTH(W), .N(NC)) bus_rl ();
   mux_arb_rr_if #(.WIDTH(W), .N(NC)) bus_fp ();
   mux_arb_rr_if #(.WIDTH(W), .N(NC)) bus_nl ();

   mux_arb_rr #(.WIDTH(W), .N(NC), .RR(1), .LOCK_EN(1)) u_rl (
      .clk(clk), .rst_n(rst_n), .bus(bus_rl));
   mux_arb_rr #(.WIDTH(W), .N(NC), .RR(0), .LOCK_EN(1)) u_fp (
      .clk(clk), .rst_n(rst_n), .bus(bus_fp));
   mux_arb_rr #(.WIDTH(W), .N(NC), .RR(1), .LOCK_EN(0)) u_nl (
      .clk(clk), .rst_n(rst_n), .bus(bus_nl));

   assign bus_rl.in_valid  = (sel == 0) ? drv_valid : '0;
   assign bus_fp.in_valid  = (sel == 1) ? drv_valid : '0;
   assign bus_nl.in_valid  = (sel == 2) ? drv_valid : '0;
   assign bus_rl.in_data   = drv_data;
   assign bus_fp.in_data   = drv_data;
   assign bus_nl.in_data   = drv_data;
   assign bus_rl.in_last   = drv_last;
   assign bus_fp.in_last   = drv_last;
   assign bus_nl.in_last   = drv_last;
   assign bus_rl.out_ready = drv_ordy;
   assign bus_fp.out_ready = drv_ordy;
   assign bus_nl.out_ready = drv_ordy;

   always_comb begin
      case (sel)
         0: begin
            obs_ready = bus_rl.in_ready;  obs_valid = bus_rl.out_valid;
            obs_data  = bus_rl.out_data;  obs_last  = bus_rl.out_last;
            obs_grant = bus_rl.out_grant; obs_idx   = bus_rl.out_idx;
         end
         1: begin
            obs_ready = bus_fp.in_ready;  obs_valid = bus_fp.out_valid;
            obs_data  = bus_fp.out_data;  obs_last  = bus_fp.out_last;
            obs_grant = bus_fp.out_grant; obs_idx   = bus_fp.out_idx;
         end
         default: begin
            obs_ready = bus_nl.in_ready;  obs_valid = bus_nl.out_valid;
            obs_data  = bus_nl.out_data;  obs_last  = bus_nl.out_last;
            obs_grant = bus_nl.out_grant; obs_idx   = bus_nl.out_idx;
         end
      endcase
   end

   function automatic logic [W-1:0] word(input int i);
      return 32'(i) * 32'h1111_1111 + cnt[i];
   endfunction

   function automatic vec_t mk(input logic r, input logic [1:0] s, input logic [NC-1:0] v,
                               input logic [NC-1:0] l, input logic o,
                               input logic [NC-1:0] e);
      vec_t t;
      t.rst = r; t.sel = s; t.valid = v; t.last = l; t.ordy = o; t.exp_ready = e;
      return t;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_model();
      sb.delete();
      for (int i = 0; i < NC; i++) cnt[i] = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      drv_valid = '0;
      drv_last  = '0;
      drv_ordy  = 1'b1;
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock: drive at negedge, check comb ready and the held output beat,
   // then record whatever the bench expects to be accepted at the next edge.
   task automatic run_vec(input vec_t v, input string tag);
      beat_t b;
      @(negedge clk);
      drv_valid = v.valid;
      drv_last  = v.last;
      drv_ordy  = v.ordy;
      for (int i = 0; i < NC; i++) drv_data[i*W +: W] = word(i);
      #1;
      check({tag, " in_ready"}, 64'(obs_ready), 64'(v.exp_ready));
      check({tag, " out_valid"}, 64'(obs_valid), 64'(sb.size() != 0));
      if (obs_valid && sb.size() != 0) begin
         b = sb[0];
         check({tag, " out_data"}, 64'(obs_data), 64'(b.data));
         check({tag, " out_idx"}, 64'(obs_idx), 64'(b.idx));
         check({tag, " out_last"}, 64'(obs_last), 64'(b.last));
         check({tag, " out_grant"}, 64'(obs_grant), 64'(NC'(1) << b.idx));
         if (v.ordy) b = sb.pop_front();
      end
      for (int i = 0; i < NC; i++) begin
         if (v.valid[i] && v.exp_ready[i]) begin
            b.idx  = IW'(i);
            b.data = word(i);
            b.last = v.last[i];
            sb.push_back(b);
            cnt[i]++;
         end
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      sel       = 0;
      rst_n     = 1'b1;
      drv_valid = '0;
      drv_last  = '0;
      drv_data  = '0;
      drv_ordy  = 1'b1;
      clear_model();

      // Round-robin, no lock, last ignored: 0,1,2,3,0 one per clock.
      tbl.push_back(mk(1, 2, 4'b1111, 4'b0000, 1, 4'b0001));
      tbl.push_back(mk(0, 2, 4'b1111, 4'b0000, 1, 4'b0010));
      tbl.push_back(mk(0, 2, 4'b1111, 4'b0000, 1, 4'b0100));
      tbl.push_back(mk(0, 2, 4'b1111, 4'b0000, 1, 4'b1000));
      tbl.push_back(mk(0, 2, 4'b1111, 4'b0000, 1, 4'b0001));
      tbl.push_back(mk(0, 2, 4'b0000, 4'b0000, 1, 4'b0000));
      tbl.push_back(mk(0, 2, 4'b0000, 4'b0000, 1, 4'b0000));
      // Fixed priority: ch1 always beats ch3.
      tbl.push_back(mk(1, 1, 4'b1010, 4'b1010, 1, 4'b0010));
      tbl.push_back(mk(0, 1, 4'b1010, 4'b1010, 1, 4'b0010));
      tbl.push_back(mk(0, 1, 4'b1010, 4'b1010, 1, 4'b0010));
      tbl.push_back(mk(0, 1, 4'b1011, 4'b1011, 1, 4'b0001));
      tbl.push_back(mk(0, 1, 4'b1010, 4'b1010, 1, 4'b0010));
      tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 4'b0000));
      tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 1, 4'b0000));
      // Backpressure for 3 clocks, then reload without a bubble.
      tbl.push_back(mk(1, 0, 4'b1111, 4'b1111, 1, 4'b0001));
      tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 0, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b1111, 4'b1111, 1, 4'b0010));
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000));
      // Lock: ch2 three beats with a 2-clock gap; ch0 waits; then ch3 (ptr=3).
      tbl.push_back(mk(1, 0, 4'b0100, 4'b0000, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b0101, 4'b0001, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b0101, 4'b0101, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b1001, 4'b1111, 1, 4'b1000));
      tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 1, 4'b0001));
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000));
      // Wrap: ptr=3 -> ch0, then ptr=1 -> ch2.
      tbl.push_back(mk(1, 0, 4'b0100, 4'b0100, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b0101, 4'b0101, 1, 4'b0001));
      tbl.push_back(mk(0, 0, 4'b0101, 4'b0101, 1, 4'b0100));
      tbl.push_back(mk(0, 0, 4'b0001, 4'b0101, 1, 4'b0001));
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000));
      tbl.push_back(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000));

      // Reset state of every instance, with all requests raised.
      #2;
      rst_n     = 1'b0;
      drv_valid = '1;
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         check($sformatf("rst%0d in_ready", s), 64'(obs_ready), 64'(0));
         check($sformatf("rst%0d out_valid", s), 64'(obs_valid), 64'(0));
         check($sformatf("rst%0d out_data", s), 64'(obs_data), 64'(0));
         check($sformatf("rst%0d out_last", s), 64'(obs_last), 64'(0));
         check($sformatf("rst%0d out_grant", s), 64'(obs_grant), 64'(0));
         check($sformatf("rst%0d out_idx", s), 64'(obs_idx), 64'(0));
      end
      drv_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         if (tbl[k].rst) begin
            sel = int'(tbl[k].sel);
            do_reset();
         end
         run_vec(tbl[k], $sformatf("v%0d", k));
      end

      // Async reset while locked with a held output beat.
      sel = 0;
      do_reset();
      run_vec(mk(0, 0, 4'b0100, 4'b0000, 1, 4'b0100), "arst lock");
      @(negedge clk);
      drv_valid = 4'b1111;
      drv_last  = 4'b1111;
      drv_ordy  = 1'b0;
      #1;
      check("arst pre out_valid", 64'(obs_valid), 64'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("arst out_valid", 64'(obs_valid), 64'(0));
      check("arst in_ready", 64'(obs_ready), 64'(0));
      drv_valid = '0;
      drv_ordy  = 1'b1;
      clear_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_vec(mk(0, 0, 4'b1111, 4'b1111, 1, 4'b0001), "arst first");
      run_vec(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000), "arst drain0");
      run_vec(mk(0, 0, 4'b0000, 4'b0000, 1, 4'b0000), "arst drain1");
      check("scoreboard empty", 64'(sb.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
